// File: rtl/x_common_pkg.sv
// Types and constants shared by the switch read-side adapters.
package x_common_pkg;

    typedef logic [1:0] occ_t;

    localparam int XDRAIN_ENTRIES = 2;

endpackage

// File: rtl/x_skid_buf2.sv
// Two-entry shift buffer. A pop shifts b1 into b0, then a push fills the lowest free entry.
module x_skid_buf2
    import x_common_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output occ_t          occ,
    output logic [DW-1:0] head
);

    occ_t          occ_q, occ_d, occ_mid;
    logic [DW-1:0] b0_q, b0_d;
    logic [DW-1:0] b1_q, b1_d;

    always_comb begin
        occ_d   = occ_q;
        occ_mid = occ_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        if (clear) begin
            occ_d = '0;
        end else begin
            if (pop && (occ_q != '0)) begin
                b0_d    = b1_q;
                occ_mid = occ_q - 2'd1;
            end
            if (push) begin
                if (occ_mid == '0) begin
                    b0_d = push_data;
                end else begin
                    b1_d = push_data;
                end
                occ_d = occ_mid + 2'd1;
            end else begin
                occ_d = occ_mid;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q <= '0;
            b0_q  <= '0;
            b1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            b0_q  <= b0_d;
            b1_q  <= b1_d;
        end
    end

    assign occ  = occ_q;
    assign head = b0_q;

endmodule

// File: rtl/x_fifo_drain.sv
// Drains a FIFO through re/empty_n/dout and presents a registered valid/ready stream,
// hiding the FIFO read latency behind a 2-entry buffer.
module x_fifo_drain
    import x_common_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_empty_n,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_dout,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output occ_t          level
);

    occ_t       occ;
    logic       infl;
    logic       pop;
    logic       cap;
    logic [2:0] pend;

    assign pop  = m_valid & m_ready;
    // Words owned after this edge; the m_ready -> fifo_re path is what allows 1 word/cycle.
    assign pend = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    assign fifo_re = fifo_empty_n & ~flush & (pend < 3'(XDRAIN_ENTRIES));

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign infl = 1'b0;
            assign cap  = fifo_re;
        end else begin : g_lat1
            logic infl_q;

            // fifo_re is already low during flush, so a flush also clears the in-flight flag.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    infl_q <= 1'b0;
                end else begin
                    infl_q <= fifo_re;
                end
            end

            assign infl = infl_q;
            assign cap  = infl_q & ~flush;
        end
    endgenerate

    x_skid_buf2 #(
        .DW(DW)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (flush),
        .push      (cap),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head      (m_data)
    );

    assign m_valid = (occ != '0);
    assign level   = occ;

endmodule

// File: tb/tb_x_fifo_drain.sv
// Self-checking bench: lane 0 is an RD_LAT=0 instance, lane 1 an RD_LAT=1 instance, each fed by
// its own FIFO model holding the same words; output order is checked against the words loaded.
module tb_x_fifo_drain;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       flush = 1'b0;
    logic       m_ready = 1'b0;

    logic       empty_n [2];
    logic       re      [2];
    logic       valid   [2];
    logic [7:0] data    [2];
    logic [1:0] level   [2];
    logic [7:0] dout0;
    logic [7:0] dout1;

    logic [7:0] mem    [2][256];
    logic [7:0] wr_ptr [2];
    logic [7:0] rd_ptr [2];

    logic [7:0] sent[$];
    logic [7:0] got [2][$];
    logic [7:0] exp_q [2][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    x_fifo_drain #(.DW(8), .RD_LAT(0)) u_dut0 (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_empty_n (empty_n[0]),
        .fifo_re      (re[0]),
        .fifo_dout    (dout0),
        .flush        (flush),
        .m_valid      (valid[0]),
        .m_ready      (m_ready),
        .m_data       (data[0]),
        .level        (level[0])
    );

    x_fifo_drain #(.DW(8), .RD_LAT(1)) u_dut1 (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_empty_n (empty_n[1]),
        .fifo_re      (re[1]),
        .fifo_dout    (dout1),
        .flush        (flush),
        .m_valid      (valid[1]),
        .m_ready      (m_ready),
        .m_data       (data[1]),
        .level        (level[1])
    );

    // FIFO models: lane 0 returns data combinationally, lane 1 one cycle after the read.
    assign empty_n[0] = rstn && (rd_ptr[0] != wr_ptr[0]);
    assign empty_n[1] = rstn && (rd_ptr[1] != wr_ptr[1]);
    assign dout0      = mem[0][rd_ptr[0]];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr[0] <= 8'd0;
            rd_ptr[1] <= 8'd0;
            dout1     <= 8'd0;
        end else begin
            if (re[0]) rd_ptr[0] <= rd_ptr[0] + 8'd1;
            if (re[1]) begin
                rd_ptr[1] <= rd_ptr[1] + 8'd1;
                dout1     <= mem[1][rd_ptr[1]];
            end else begin
                dout1 <= 8'($urandom);
            end
        end
    end

    // Consumer: record every accepted word.
    always @(negedge clk) begin
        if (rstn) begin
            for (int l = 0; l < 2; l++) begin
                if (valid[l] && m_ready) got[l].push_back(data[l]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        for (int l = 0; l < 2; l++) begin
            mem[l][wr_ptr[l]] = v;
            wr_ptr[l] = wr_ptr[l] + 8'd1;
        end
        sent.push_back(v);
    endtask

    task automatic apply_reset();
        rstn    = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        wr_ptr[0] = 8'd0;
        wr_ptr[1] = 8'd0;
        sent.delete();
        got[0].delete();
        got[1].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        m_ready = 1'b1;
        load(8'h3C);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (valid[l] !== 1'b0) begin
                errors++; $display("FAIL reset_valid lane%0d got %b want 0", l, valid[l]);
            end
            checks++;
            if (level[l] !== 2'd0) begin
                errors++; $display("FAIL reset_level lane%0d got %0d want 0", l, level[l]);
            end
            checks++;
            if (data[l] !== 8'h00) begin
                errors++; $display("FAIL reset_data lane%0d got %0h want 0", l, data[l]);
            end
            checks++;
            if (re[l] !== 1'b0) begin
                errors++; $display("FAIL reset_re lane%0d got %b want 0", l, re[l]);
            end
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        m_ready = 1'b1;
        load(8'hA5);
        // Cycle t: both lanes issue the read immediately.
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (re[l] !== 1'b1 || valid[l] !== 1'b0) begin
                errors++; $display("FAIL single_t lane%0d got re=%b v=%b want re=1 v=0", l, re[l], valid[l]);
            end
        end
        cyc();
        @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1 || data[0] !== 8'hA5) begin
            errors++; $display("FAIL single_t1_lat0 got v=%b d=%0h want v=1 d=a5", valid[0], data[0]);
        end
        checks++;
        if (valid[1] !== 1'b0 || re[1] !== 1'b0) begin
            errors++; $display("FAIL single_t1_lat1 got v=%b re=%b want v=0 re=0", valid[1], re[1]);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (valid[1] !== 1'b1 || data[1] !== 8'hA5) begin
            errors++; $display("FAIL single_t2_lat1 got v=%b d=%0h want v=1 d=a5", valid[1], data[1]);
        end
        checks++;
        if (valid[0] !== 1'b0) begin
            errors++; $display("FAIL single_t2_lat0 got v=%b want 0", valid[0]);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (valid[1] !== 1'b0) begin
            errors++; $display("FAIL single_t3_lat1 got v=%b want 0", valid[1]);
        end
        cyc();
    endtask

    task automatic test_stream();
        int first [2];
        int last  [2];
        int nval  [2];
        int maxlev[2];
        apply_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) load(8'(i));
        for (int l = 0; l < 2; l++) begin
            first[l] = -1; last[l] = -1; nval[l] = 0; maxlev[l] = 0;
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (valid[l]) begin
                    if (first[l] < 0) first[l] = c;
                    last[l] = c;
                    nval[l]++;
                end
                if (first[l] >= 0 && int'(level[l]) > maxlev[l]) maxlev[l] = int'(level[l]);
            end
            cyc();
        end
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (nval[l] != 16 || last[l] - first[l] + 1 != 16) begin
                errors++;
                $display("FAIL stream_run lane%0d got %0d valid over %0d cycles want 16 over 16",
                         l, nval[l], last[l] - first[l] + 1);
            end
            checks++;
            if (maxlev[l] > 1) begin
                errors++; $display("FAIL stream_level lane%0d got %0d want <=1", l, maxlev[l]);
            end
            checks++;
            if (got[l].size() != sent.size()) begin
                errors++; $display("FAIL stream_count lane%0d got %0d want %0d", l, got[l].size(), sent.size());
            end
            for (int i = 0; i < sent.size() && i < got[l].size(); i++) begin
                checks++;
                if (got[l][i] !== sent[i]) begin
                    errors++; $display("FAIL stream_data lane%0d idx %0d got %0h want %0h", l, i, got[l][i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held [2];
        int reads [2];
        int unstable [2];
        apply_reset();
        for (int i = 0; i < 8; i++) load(8'($urandom));
        m_ready = 1'b1;
        repeat (3) cyc();
        m_ready = 1'b0;
        for (int l = 0; l < 2; l++) begin
            reads[l] = 0; unstable[l] = 0;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (re[l]) reads[l]++;
                if (c == 0) held[l] = data[l];
                else if (!valid[l] || data[l] !== held[l]) unstable[l]++;
            end
            cyc();
        end
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (level[l] !== 2'd2) begin
                errors++; $display("FAIL bp_level lane%0d got %0d want 2", l, level[l]);
            end
            checks++;
            if (reads[l] > 2 || re[l] !== 1'b0) begin
                errors++; $display("FAIL bp_reads lane%0d got %0d reads re=%b want <=2 re=0", l, reads[l], re[l]);
            end
            checks++;
            if (unstable[l] != 0) begin
                errors++; $display("FAIL bp_stable lane%0d got %0d changes want 0", l, unstable[l]);
            end
        end
        cyc();
        m_ready = 1'b1;
        repeat (16) cyc();
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (got[l].size() != sent.size()) begin
                errors++; $display("FAIL bp_count lane%0d got %0d want %0d", l, got[l].size(), sent.size());
            end
            for (int i = 0; i < sent.size() && i < got[l].size(); i++) begin
                checks++;
                if (got[l][i] !== sent[i]) begin
                    errors++; $display("FAIL bp_data lane%0d idx %0d got %0h want %0h", l, i, got[l][i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_pop_capture();
        apply_reset();
        for (int i = 0; i < 6; i++) load(8'($urandom));
        m_ready = 1'b0;
        repeat (4) cyc();
        m_ready = 1'b1;
        // Lane 0 is full: this cycle pops and captures on the same edge.
        @(negedge clk);
        checks++;
        if (level[0] !== 2'd2 || re[0] !== 1'b1) begin
            errors++; $display("FAIL popcap_pre got level=%0d re=%b want level=2 re=1", level[0], re[0]);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (level[0] !== 2'd2 || valid[0] !== 1'b1) begin
            errors++; $display("FAIL popcap_post got level=%0d v=%b want level=2 v=1", level[0], valid[0]);
        end
        repeat (12) cyc();
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (got[l].size() != sent.size()) begin
                errors++; $display("FAIL popcap_count lane%0d got %0d want %0d", l, got[l].size(), sent.size());
            end
            for (int i = 0; i < sent.size() && i < got[l].size(); i++) begin
                checks++;
                if (got[l][i] !== sent[i]) begin
                    errors++; $display("FAIL popcap_data lane%0d idx %0d got %0h want %0h", l, i, got[l][i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        int dropped [2];
        apply_reset();
        for (int i = 0; i < 12; i++) load(8'($urandom));
        m_ready = 1'b1;
        repeat (4) cyc();
        flush   = 1'b1;
        m_ready = 1'b0;
        // Words handed out by the FIFO but never accepted are lost; the rest follow in order.
        for (int l = 0; l < 2; l++) begin
            exp_q[l].delete();
            for (int i = 0; i < got[l].size(); i++) exp_q[l].push_back(sent[i]);
            for (int i = int'(rd_ptr[l]); i < sent.size(); i++) exp_q[l].push_back(sent[i]);
            dropped[l] = int'(rd_ptr[l]) - got[l].size();
        end
        checks++;
        if (dropped[1] != 2 || dropped[0] != 1) begin
            errors++; $display("FAIL flush_setup got dropped %0d/%0d want 1/2", dropped[0], dropped[1]);
        end
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (re[l] !== 1'b0) begin
                errors++; $display("FAIL flush_re lane%0d got %b want 0", l, re[l]);
            end
        end
        cyc();
        flush   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (valid[l] !== 1'b0 || level[l] !== 2'd0) begin
                errors++; $display("FAIL flush_valid lane%0d got v=%b level=%0d want 0", l, valid[l], level[l]);
            end
        end
        repeat (20) cyc();
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (got[l].size() != exp_q[l].size()) begin
                errors++; $display("FAIL flush_count lane%0d got %0d want %0d", l, got[l].size(), exp_q[l].size());
            end
            for (int i = 0; i < exp_q[l].size() && i < got[l].size(); i++) begin
                checks++;
                if (got[l][i] !== exp_q[l][i]) begin
                    errors++; $display("FAIL flush_data lane%0d idx %0d got %0h want %0h", l, i, got[l][i], exp_q[l][i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) load(8'($urandom));
        m_ready = 1'b1;
        repeat (4) cyc();
        #2;
        rstn = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (valid[l] !== 1'b0 || level[l] !== 2'd0 || data[l] !== 8'h00) begin
                errors++;
                $display("FAIL areset lane%0d got v=%b level=%0d d=%0h want 0/0/0", l, valid[l], level[l], data[l]);
            end
        end
        apply_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) load(8'($urandom));
        repeat (12) cyc();
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (got[l].size() != sent.size()) begin
                errors++; $display("FAIL areset_count lane%0d got %0d want %0d", l, got[l].size(), sent.size());
            end
            for (int i = 0; i < sent.size() && i < got[l].size(); i++) begin
                checks++;
                if (got[l][i] !== sent[i]) begin
                    errors++; $display("FAIL areset_data lane%0d idx %0d got %0h want %0h", l, i, got[l][i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] held [2];
        logic stall [2];
        int viol [2];
        int over [2];
        apply_reset();
        for (int i = 0; i < 60; i++) load(8'($urandom));
        for (int l = 0; l < 2; l++) begin
            stall[l] = 1'b0; viol[l] = 0; over[l] = 0;
        end
        for (int c = 0; c < 200; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (stall[l] && (!valid[l] || data[l] !== held[l])) viol[l]++;
                if (level[l] > 2'd2) over[l]++;
                stall[l] = valid[l] && !m_ready;
                held[l]  = data[l];
            end
            cyc();
        end
        m_ready = 1'b1;
        repeat (10) cyc();
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (viol[l] != 0 || over[l] != 0) begin
                errors++; $display("FAIL rand_stable lane%0d got %0d/%0d violations want 0", l, viol[l], over[l]);
            end
            checks++;
            if (got[l].size() != sent.size()) begin
                errors++; $display("FAIL rand_count lane%0d got %0d want %0d", l, got[l].size(), sent.size());
            end
            for (int i = 0; i < sent.size() && i < got[l].size(); i++) begin
                checks++;
                if (got[l][i] !== sent[i]) begin
                    errors++; $display("FAIL rand_data lane%0d idx %0d got %0h want %0h", l, i, got[l][i], sent[i]);
                end
            end
        end
    endtask

    initial begin
        wr_ptr[0] = 8'd0;
        wr_ptr[1] = 8'd0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_pop_capture();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
